// File: rtl/pid_drive.sv
// rtl/pid_drive.sv - decimated PID stage producing the 12-bit motor drive magnitude; optional D path via PID_DERIV_EN
module pid_drive #(
  parameter int DECIM_W = 20,
  parameter int D_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] error,
  input  logic        not_pedaling,
  output logic [11:0] drv_mag
);

  localparam logic [16:0] INTEG_MAX = 17'h1FFFF;

  logic [DECIM_W-1:0] cnt;
  logic               tick;
  logic [16:0]        integ;
  logic signed [18:0] i_sum;
  logic [16:0]        i_next;
  logic signed [14:0] p_term;
  logic signed [14:0] i_term;
  logic signed [14:0] d_term;
  logic signed [14:0] s_sum;
  logic [11:0]        drv_next;

  assign tick = &cnt;

  // Free-running decimator; keeps counting through not_pedaling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // Integrator sum is carried at 19 bits so a full integrator plus a positive
  // error cannot wrap negative before the clamp.
  always_comb begin
    i_sum  = $signed({2'b00, integ}) + $signed({{6{error[12]}}, error});
    i_next = i_sum[16:0];
    if (i_sum[18])
      i_next = '0;
    else if (i_sum > $signed({2'b00, INTEG_MAX}))
      i_next = INTEG_MAX;
  end

  // Integrator state: cleared by not_pedaling, otherwise updated on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            integ <= '0;
    else if (not_pedaling) integ <= '0;
    else if (tick)         integ <= i_next;
  end

`ifdef PID_DERIV_EN
  logic [D_DEPTH-1:0][12:0] hist;
  logic signed [13:0]       d_diff;
  logic signed [9:0]        d_sat;
  logic signed [13:0]       d_reg;

  // Difference against the oldest queued error, saturated to 10 bits
  always_comb begin
    d_diff = $signed({error[12], error}) - $signed({hist[D_DEPTH-1][12], hist[D_DEPTH-1]});
    d_sat  = d_diff[9:0];
    if (d_diff > 14'sd511)
      d_sat = 10'sh1FF;
    else if (d_diff < -14'sd512)
      d_sat = 10'sh200;
  end

  // Error history and D register, both advanced only on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      d_reg <= '0;
    end else if (not_pedaling) begin
      hist  <= '0;
      d_reg <= '0;
    end else if (tick) begin
      d_reg <= {{2{d_sat[9]}}, d_sat, 2'b00};
      for (int i = D_DEPTH - 1; i > 0; i--)
        hist[i] <= hist[i-1];
      hist[0] <= error;
    end
  end

  assign d_term = {d_reg[13], d_reg};
`else
  assign d_term = '0;
`endif

  // P is the sign-extended live error; I is the integrator's top 12 bits
  always_comb begin
    p_term   = {{2{error[12]}}, error};
    i_term   = {3'b000, integ[16:5]};
    s_sum    = p_term + i_term + d_term;
    drv_next = s_sum[11:0];
    if (s_sum[14])
      drv_next = '0;
    else if (s_sum > 15'sd4095)
      drv_next = 12'hFFF;
  end

  // Registered drive output, forced to zero while the rider is not pedaling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            drv_mag <= '0;
    else if (not_pedaling) drv_mag <= '0;
    else                   drv_mag <= drv_next;
  end

endmodule

// File: tb/tb_pid_drive.sv
// tb/tb_pid_drive.sv - scoreboard bench for pid_drive with a short decimator
module tb_pid_drive;

  localparam int DECIM_W = 4;
  localparam int D_DEPTH = 3;

  logic        clk;
  logic        rst_n;
  logic [12:0] error;
  logic        not_pedaling;
  logic [11:0] drv_mag;

  int checks   = 0;
  int failures = 0;
  int sb[$];

  pid_drive #(.DECIM_W(DECIM_W), .D_DEPTH(D_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .error        (error),
    .not_pedaling (not_pedaling),
    .drv_mag      (drv_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_cnt, m_integ, m_dreg;
`ifdef PID_DERIV_EN
  int m_hist[D_DEPTH];
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_integ <= 0;
      m_dreg  <= 0;
`ifdef PID_DERIV_EN
      for (int i = 0; i < D_DEPTH; i++) m_hist[i] <= 0;
`endif
      sb.delete();
    end else begin
      automatic int e = int'($signed(error));
      automatic int s = e + (m_integ >> 5) + m_dreg;
      automatic int x = (s < 0) ? 0 : ((s > 4095) ? 4095 : s);
      automatic int n = m_integ + e;
      if (not_pedaling) x = 0;
      sb.push_back(x);
      if (not_pedaling) begin
        m_integ <= 0;
        m_dreg  <= 0;
`ifdef PID_DERIV_EN
        for (int i = 0; i < D_DEPTH; i++) m_hist[i] <= 0;
`endif
      end else if (m_cnt == (1 << DECIM_W) - 1) begin
        m_integ <= (n < 0) ? 0 : ((n > 131071) ? 131071 : n);
`ifdef PID_DERIV_EN
        begin
          automatic int d = e - m_hist[D_DEPTH-1];
          if (d > 511) d = 511;
          if (d < -512) d = -512;
          m_dreg <= d * 4;
          for (int i = D_DEPTH - 1; i > 0; i--) m_hist[i] <= m_hist[i-1];
          m_hist[0] <= e;
        end
`endif
      end
      m_cnt <= (m_cnt + 1) % (1 << DECIM_W);
    end
  end

  // Compare each registered output against the model's prediction
  always @(negedge clk) begin
    if (sb.size() > 0) check("sb_drv", int'(drv_mag), sb.pop_front());
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef PID_DERIV_EN
  localparam int EXP_T1 = 1288;
  localparam int EXP_T2 = 1296;
  localparam int EXP_T3 = 1304;
`else
  localparam int EXP_T1 = 264;
  localparam int EXP_T2 = 272;
  localparam int EXP_T3 = 280;
`endif

  initial begin
    rst_n        = 1'b0;
    error        = 13'h0100;
    not_pedaling = 1'b0;
    step(3);
    check("reset_drv", int'(drv_mag), 0);
    error = 13'h0000;
    rst_n = 1'b1;
    step(40);
    check("zero_err", int'(drv_mag), 0);

    // P/I/D path from a fresh reset; counter is 0 at release
    rst_n = 1'b0;
    error = 13'h0100;
    step(1);
    rst_n = 1'b1;
    step(1);
    check("p_only", int'(drv_mag), 256);
    step(15);
    check("pre_tick1", int'(drv_mag), 256);
    step(1);
    check("tick1", int'(drv_mag), EXP_T1);
    step(16);
    check("tick2", int'(drv_mag), EXP_T2);
    step(16);
    check("tick3", int'(drv_mag), EXP_T3);
    step(16);
    check("tick4", int'(drv_mag), 288);

    // Integrator saturation
    error = 13'h0FFF;
    step(40 * 16);
    check("sat_drv", int'(drv_mag), 4095);
    check("sat_integ", int'(dut.integ), 131071);

    // not_pedaling lands on the tick at posedge 720 (now past posedge 705)
    step(14);
    not_pedaling = 1'b1;
    step(1);
    check("np_drv", int'(drv_mag), 0);
    check("np_integ", int'(dut.integ), 0);
    not_pedaling = 1'b0;
    error = 13'h0100;
    step(1);
    check("np_release", int'(drv_mag), 256);

    // Negative clamp: integrator must stay at zero
    error = 13'h1000;
    step(48);
    check("neg_drv", int'(drv_mag), 0);
    check("neg_integ", int'(dut.integ), 0);

    // Asynchronous reset between edges
    error = 13'h0100;
    step(40);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_drv", int'(drv_mag), 0);
    check("areset_integ", int'(dut.integ), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("areset_release", int'(drv_mag), 256);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
